// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-ported data
// memory. Each access takes one IDLE (arbitrate) cycle and one ACCESS cycle, so
// grants come at most once every two cycles. The response is registered at the
// edge that ends ACCESS.
module dmem_arbiter #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int MEM_DEPTH = 256
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_a,
   input  logic              i_we_a,
   input  logic [ADDR_W-1:0] i_addr_a,
   input  logic [DATA_W-1:0] i_wdata_a,
   input  logic              i_req_b,
   input  logic              i_we_b,
   input  logic [ADDR_W-1:0] i_addr_b,
   input  logic [DATA_W-1:0] i_wdata_b,
   output logic              o_gnt_a,
   output logic              o_gnt_b,
   output logic              o_rvalid_a,
   output logic              o_rvalid_b,
   output logic [DATA_W-1:0] o_rdata_a,
   output logic [DATA_W-1:0] o_rdata_b,
   output logic              o_err_a,
   output logic              o_err_b,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_mem_write,
   output logic              o_mem_read,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   localparam logic [ADDR_W-1:0] DEPTH_ADDR = ADDR_W'(MEM_DEPTH);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic                last_b_q, last_b_d;    // 1 = port B was granted last
   logic                sel_b_q, sel_b_d;      // winner of the access in flight
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                rvalid_a_q, rvalid_a_d;
   logic                rvalid_b_q, rvalid_b_d;
   logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
   logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;
   logic                err_a_q, err_a_d;
   logic                err_b_q, err_b_d;

   logic                any_req;
   logic                pick_b;
   logic                in_range;
   logic [DATA_W-1:0]   rsp_data;

   assign any_req  = i_req_a | i_req_b;
   // B wins when it is alone, or on a tie when A was granted last.
   assign pick_b   = i_req_b & (~i_req_a | ~last_b_q);
   assign in_range = (mem_addr_q < DEPTH_ADDR);
   assign rsp_data = (in_range && !we_q) ? i_mem_rdata : '0;

   // State register; reset drops straight back to IDLE, killing any in-flight access.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state: ACCESS always lasts exactly one cycle.
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (any_req) state_d = S_ACCESS;
         S_ACCESS: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // FSM outputs: grant and memory enables are live only during ACCESS.
   always_comb begin
      o_gnt_a     = 1'b0;
      o_gnt_b     = 1'b0;
      o_mem_write = 1'b0;
      o_mem_read  = 1'b0;
      if (state_q == S_ACCESS) begin
         o_gnt_a     = ~sel_b_q;
         o_gnt_b     = sel_b_q;
         o_mem_write = in_range & we_q;
         o_mem_read  = in_range & ~we_q;
      end
   end

   // Datapath next values: latch the winner's request in IDLE, build the response in ACCESS.
   always_comb begin
      last_b_d    = last_b_q;
      sel_b_d     = sel_b_q;
      we_d        = we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rvalid_a_d  = 1'b0;
      rvalid_b_d  = 1'b0;
      rdata_a_d   = '0;
      rdata_b_d   = '0;
      err_a_d     = 1'b0;
      err_b_d     = 1'b0;
      if (state_q == S_IDLE && any_req) begin
         sel_b_d     = pick_b;
         last_b_d    = pick_b;
         we_d        = pick_b ? i_we_b    : i_we_a;
         mem_addr_d  = pick_b ? i_addr_b  : i_addr_a;
         mem_wdata_d = pick_b ? i_wdata_b : i_wdata_a;
      end
      if (state_q == S_ACCESS) begin
         if (sel_b_q) begin
            rvalid_b_d = 1'b1;
            rdata_b_d  = rsp_data;
            err_b_d    = ~in_range;
         end else begin
            rvalid_a_d = 1'b1;
            rdata_a_d  = rsp_data;
            err_a_d    = ~in_range;
         end
      end
   end

   // Datapath registers; the pointer resets to B so A wins the first tie.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_b_q    <= 1'b1;
         sel_b_q     <= 1'b0;
         we_q        <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rvalid_a_q  <= 1'b0;
         rvalid_b_q  <= 1'b0;
         rdata_a_q   <= '0;
         rdata_b_q   <= '0;
         err_a_q     <= 1'b0;
         err_b_q     <= 1'b0;
      end else begin
         last_b_q    <= last_b_d;
         sel_b_q     <= sel_b_d;
         we_q        <= we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rvalid_a_q  <= rvalid_a_d;
         rvalid_b_q  <= rvalid_b_d;
         rdata_a_q   <= rdata_a_d;
         rdata_b_q   <= rdata_b_d;
         err_a_q     <= err_a_d;
         err_b_q     <= err_b_d;
      end
   end

   assign o_rvalid_a  = rvalid_a_q;
   assign o_rvalid_b  = rvalid_b_q;
   assign o_rdata_a   = rdata_a_q;
   assign o_rdata_b   = rdata_b_q;
   assign o_err_a     = err_a_q;
   assign o_err_b     = err_b_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table of single accesses plus hand-written sequences for
// the round-robin tie, out-of-range and reset-during-access cases. Responses
// are matched against a scoreboard queue filled when each request is driven.
module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req_a, we_a, req_b, we_b;
   logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
   logic        gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b;
   logic [31:0] rdata_a, rdata_b, mem_addr, mem_wdata, mem_rdata;
   logic        mem_write, mem_read;

   dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(256)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_a     (req_a),
      .i_we_a      (we_a),
      .i_addr_a    (addr_a),
      .i_wdata_a   (wdata_a),
      .i_req_b     (req_b),
      .i_we_b      (we_b),
      .i_addr_b    (addr_b),
      .i_wdata_b   (wdata_b),
      .o_gnt_a     (gnt_a),
      .o_gnt_b     (gnt_b),
      .o_rvalid_a  (rvalid_a),
      .o_rvalid_b  (rvalid_b),
      .o_rdata_a   (rdata_a),
      .o_rdata_b   (rdata_b),
      .o_err_a     (err_a),
      .o_err_b     (err_b),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .o_mem_write (mem_write),
      .o_mem_read  (mem_read),
      .i_mem_rdata (mem_rdata)
   );

   typedef struct {
      bit          port_b;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   typedef struct {
      bit          port_b;
      logic [31:0] rdata;
      bit          err;
      int          cyc;
   } exp_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t sb[$];
   vec_t vecs[10];

   // Data memory model: combinational read, write at the rising edge.
   logic [31:0] mem [256];
   assign mem_rdata = (mem_read && mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'hBAD0_BAD0;
   always @(posedge clk) if (mem_write && mem_addr < 32'd256) mem[mem_addr[7:0]] <= mem_wdata;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response monitor: every rvalid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rvalid_a || rvalid_b) begin
         check("rvalid_onehot", {63'd0, rvalid_a & rvalid_b}, 64'd0);
         check("mem_en_outside_access", {62'd0, mem_write, mem_read}, 64'd0);
         if (sb.size() == 0) begin
            check("rvalid_pending", {62'd0, rvalid_a, rvalid_b}, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_port",  {63'd0, rvalid_b}, {63'd0, e.port_b});
            check("rsp_rdata", {32'd0, rvalid_b ? rdata_b : rdata_a}, {32'd0, e.rdata});
            check("rsp_err",   {63'd0, rvalid_b ? err_b : err_a}, {63'd0, e.err});
            check("rsp_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // Drives one access from the current cycle (called at posedge+1) and waits for its grant.
   task automatic access(input vec_t v);
      int       n;
      bit       seen;
      bit       rng;
      exp_t     e;
      logic [1:0] exp_en;
      n   = cyc;
      rng = (v.addr < 32'd256);
      if (v.port_b) begin
         req_b = 1'b1; we_b = v.we; addr_b = v.addr; wdata_b = v.wdata;
      end else begin
         req_a = 1'b1; we_a = v.we; addr_a = v.addr; wdata_a = v.wdata;
      end
      e.port_b = v.port_b;
      e.rdata  = v.exp_rdata;
      e.err    = v.exp_err;
      e.cyc    = n + 2;
      sb.push_back(e);
      exp_en = rng ? {v.we, ~v.we} : 2'b00;
      seen   = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
         @(negedge clk);
         if (v.port_b ? gnt_b : gnt_a) begin
            seen = 1'b1;
            check("gnt_latency", 64'(cyc), 64'(n + 1));
            check("gnt_other", {63'd0, v.port_b ? gnt_a : gnt_b}, 64'd0);
            check("mem_en_access", {62'd0, mem_write, mem_read}, {62'd0, exp_en});
            if (rng) check("mem_addr", {32'd0, mem_addr}, {32'd0, v.addr});
            if (rng && v.we) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, v.wdata});
         end
      end
      check("gnt_seen", {63'd0, seen}, 64'd1);
      @(posedge clk); #1;
      if (v.port_b) req_b = 1'b0;
      else          req_a = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, {56'd0, gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b, mem_write, mem_read}, 64'd0);
      check({tag, "_rdata"}, {rdata_a, rdata_b}, 64'd0);
      check({tag, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem[2] <= 32'h0000_003F;

      //           port  we  addr           wdata          exp_rdata      err
      vecs[0] = '{1'b0, 1'b0, 32'd2,        32'd0,         32'h0000_003F, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 32'd20,       32'hDEAD_BEEF, 32'd0,         1'b0};
      vecs[2] = '{1'b1, 1'b0, 32'd20,       32'd0,         32'hDEAD_BEEF, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 32'd255,      32'hCAFE_F00D, 32'd0,         1'b0};
      vecs[4] = '{1'b0, 1'b0, 32'd255,      32'd0,         32'hCAFE_F00D, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 32'd256,      32'h0000_0055, 32'd0,         1'b1};
      vecs[6] = '{1'b1, 1'b0, 32'd256,      32'd0,         32'd0,         1'b1};
      vecs[7] = '{1'b0, 1'b0, 32'd0,        32'd0,         32'h1000_0000, 1'b0};
      vecs[8] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0,        32'd0,         1'b1};
      vecs[9] = '{1'b0, 1'b0, 32'd11,       32'd0,         32'h1000_000B, 1'b0};

      rst_n = 1'b0;
      req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
      req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
      #2;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Table of single accesses, issued back to back (each new request lands in the previous rvalid cycle).
      for (int i = 0; i < 10; i++) access(vecs[i]);

      // Reset during the ACCESS cycle of a write to addr 11.
      req_a = 1'b1; we_a = 1'b1; addr_a = 32'd11; wdata_a = 32'h1;
      @(negedge clk);
      @(negedge clk);
      check("rst_mid_gnt", {62'd0, gnt_a, mem_write}, 64'd3);
      #1 rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
      repeat (3) @(negedge clk);
      check_all_zero("rst_hold");
      @(posedge clk); #1 rst_n = 1'b1;
      access('{1'b0, 1'b0, 32'd11, 32'd0, 32'h1000_000B, 1'b0});

      // Continuous tie from reset: A, B, A, B, ... one grant every two cycles.
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      check_all_zero("rst_tie");
      @(posedge clk); #1 rst_n = 1'b1;
      begin
         int   n0;
         exp_t e;
         n0 = cyc;
         for (int k = 0; k < 8; k++) begin
            e.port_b = (k % 2 == 1);
            e.rdata  = (k % 2 == 1) ? 32'hDEAD_BEEF : 32'h0000_003F;
            e.err    = 1'b0;
            e.cyc    = n0 + 2 + 2 * k;
            sb.push_back(e);
         end
         req_a = 1'b1; we_a = 1'b0; addr_a = 32'd2;
         req_b = 1'b1; we_b = 1'b0; addr_b = 32'd20;
         @(negedge clk);
         check("tie_first_idle", {62'd0, gnt_a, gnt_b}, 64'd0);
         for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            check("tie_gnt_a", {63'd0, gnt_a}, {63'd0, (c % 4 == 0)});
            check("tie_gnt_b", {63'd0, gnt_b}, {63'd0, (c % 4 == 2)});
         end
         @(posedge clk); #1;
         req_a = 1'b0; req_b = 1'b0;
         repeat (2) begin
            @(negedge clk);
            check("tie_drain_gnt", {62'd0, gnt_a, gnt_b}, 64'd0);
         end
      end

      repeat (3) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, 32, data word width of the data memory and both requester ports.
REQ-002 Parameter ADDR_W, 32, address width of requester and memory ports (word address).
REQ-003 Parameter MEM_DEPTH, 256, number of implemented memory words; addresses >= MEM_DEPTH are out of range.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low: ports i_clk and i_rst_n.
REQ-005 i_clk  in  1  rising-edge clock, shared with the data memory.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_req_a / i_req_b  in  1  access request, port A (core load/store) / port B (debug/DMA).
REQ-008 i_we_a / i_we_b  in  1  1 = write, 0 = read; valid while the matching req is high.
REQ-009 i_addr_a / i_addr_b  in  ADDR_W  word address.
REQ-010 i_wdata_a / i_wdata_b  in  DATA_W  write data.
REQ-011 o_gnt_a / o_gnt_b  out  1  one-cycle grant pulse.
REQ-012 o_rvalid_a / o_rvalid_b  out  1  one-cycle response pulse; also acknowledges writes.
REQ-013 o_rdata_a / o_rdata_b  out  DATA_W  read data, valid with rvalid.
REQ-014 o_err_a / o_err_b  out  1  out-of-range flag, valid with rvalid.
REQ-015 o_mem_addr  out  ADDR_W  memory address.
REQ-016 o_mem_wdata  out  DATA_W  memory write data.
REQ-017 o_mem_write / o_mem_read  out  1  memory write and read enables.
REQ-018 i_mem_rdata  in  DATA_W  memory read data; combinational from o_mem_addr when o_mem_read = 1.

Function
REQ-019 The FSM SHALL have two states: IDLE and ACCESS; reset state is IDLE.
REQ-020 In IDLE with any req high, the block SHALL select one port, latch its we/addr/wdata into o_mem_*, and enter ACCESS at the next edge.
REQ-021 If only one req is high, that port wins; if both are high, the port not granted last wins; the last-granted pointer resets to B so A wins the first tie.
REQ-022 In ACCESS, the winning port's o_gnt SHALL be 1 for exactly that cycle; the other port's o_gnt SHALL be 0.
REQ-023 In ACCESS with an in-range address, the block SHALL assert o_mem_write = we and o_mem_read = !we; the memory write commits at the edge ending ACCESS.
REQ-024 In ACCESS with an out-of-range address, o_mem_write and o_mem_read SHALL both stay 0.
REQ-025 At the edge ending ACCESS, the block SHALL register the response: rvalid = 1 for one cycle; rdata = i_mem_rdata for an in-range read, else 0; err = 1 only when out of range.
REQ-026 ACCESS SHALL always return to IDLE after one cycle, giving grant-to-grant throughput of one access per 2 cycles.
REQ-027 Latency: req high in cycle N (IDLE) -> gnt in N+1 -> rvalid/rdata in N+2.
REQ-028 The requester SHALL hold req/we/addr/wdata stable until it sees gnt, and SHALL drop req in the cycle after gnt unless it issues a new access.
REQ-029 A req still high in the rvalid cycle SHALL be treated as a new request and arbitrated in that cycle.
REQ-030 Outside ACCESS, o_mem_write and o_mem_read SHALL be 0; o_mem_addr and o_mem_wdata hold their last values.
REQ-031 At most one port's rvalid SHALL be high in any cycle.

Reset
REQ-032 While i_rst_n = 0, every output SHALL be 0, the state SHALL be IDLE, and the last-granted pointer SHALL be B; this takes effect without waiting for a clock edge.
REQ-033 Reset asserted during ACCESS SHALL force o_mem_write to 0 immediately, so the in-flight write does not commit, and no rvalid SHALL follow.
REQ-034 After release, the first arbitration SHALL occur at the first rising edge with i_rst_n = 1.

Verification
REQ-035 Single read: A reads addr 2 while memory word 2 = 0x3F -> o_gnt_a at N+1, o_rvalid_a at N+2, o_rdata_a = 0x0000003F, o_err_a = 0.
REQ-036 Write then read: B writes 0xDEADBEEF to addr 20, then reads addr 20 -> write acknowledged with rdata 0; the read returns 0xDEADBEEF.
REQ-037 Tie after reset: A and B both request continuously -> grants alternate A, B, A, B, one every 2 cycles; never two consecutive grants to the same port.
REQ-038 Out of range: A writes addr 256 -> o_mem_write stays 0 throughout, o_rvalid_a = 1 with o_err_a = 1, and memory contents are unchanged.
REQ-039 Reset mid-access: i_rst_n driven low during the ACCESS cycle of a write of 0x1 to addr 11 -> all outputs 0 at once; addr 11 keeps its old value; no rvalid after release.
